// File: rtl/pv32_mem_responder.sv
// Memory-side responder for the picorv32 native mem_* interface: word RAM, byte strobes, wait states, sticky range error.
// Optional write-only console character port enabled by defining PV32_CONSOLE_EN.
module pv32_mem_responder #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          WAIT_STATES  = 0,
  parameter string       INIT_FILE    = "",
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
`ifdef PV32_CONSOLE_EN
  ,
  output logic        console_valid,
  output logic [7:0]  console_data
`endif
);

  localparam int          LP_DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LP_WS_M1  = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_commit;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic        w_oor_raw;
  logic        w_oor;
  logic        w_con;
  logic        w_ram_we;
  logic        w_unused;

  logic [31:0] r_mem [0:LP_DEPTH-1];

  // With zero wait states the commit happens on the capture edge, so use the live request.
  assign w_addr  = (r_state == ST_IDLE) ? mem_addr  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? mem_wdata : r_wdata;
  assign w_wstrb = (r_state == ST_IDLE) ? mem_wstrb : r_wstrb;
  assign w_idx   = w_addr[ADDR_WIDTH+1:2];

  assign w_oor_raw = (w_addr >> (ADDR_WIDTH + 2)) != 32'd0;
`ifdef PV32_CONSOLE_EN
  assign w_con = (w_addr[31:2] == CONSOLE_ADDR[31:2]);
`else
  assign w_con = 1'b0;
`endif
  assign w_oor    = w_oor_raw && !w_con;
  assign w_ram_we = w_commit && resetn && (w_wstrb != 4'd0) && !w_oor && !w_con;
  assign w_unused = &{1'b0, mem_instr, w_addr[1:0], CONSOLE_ADDR[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_WS_M1;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && mem_valid) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
      end
      if (w_commit) begin
        if (w_wstrb == 4'd0) begin
          r_rdata <= (w_oor || w_con) ? 32'd0 : r_mem[w_idx];
        end
        if (w_oor) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // RAM has no reset: contents survive resetn so committed writes persist.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

`ifdef PV32_CONSOLE_EN
  logic       r_con_v;
  logic [7:0] r_con_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_con_v <= 1'b0;
      r_con_d <= 8'd0;
    end else begin
      r_con_v <= 1'b0;
      if (w_commit && w_con && w_wstrb[0]) begin
        r_con_v <= 1'b1;
        r_con_d <= w_wdata[7:0];
      end
    end
  end

  assign console_valid = r_con_v;
  assign console_data  = r_con_d;
`endif

  assign mem_ready = (r_state == ST_RESP);
  assign mem_rdata = r_rdata;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_pv32_mem_responder.sv
// Directed bench for pv32_mem_responder: one zero-wait-state and one three-wait-state instance sharing the bus.
module tb_pv32_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        v0, v3;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        r0, r3, e0, e3;
  logic [31:0] rd0, rd3;
  logic        cv0, cv3;
  logic [7:0]  cd0, cd3;
  logic        last_cv_at, last_cv_after;
  logic [7:0]  last_cd_at;
  logic [31:0] rd;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          seen;

  always #5 clk = ~clk;

  pv32_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(r0), .mem_rdata(rd0), .mem_err(e0)
`ifdef PV32_CONSOLE_EN
    , .console_valid(cv0), .console_data(cd0)
`endif
  );

  pv32_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .resetn(resetn), .mem_valid(v3), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(r3), .mem_rdata(rd3), .mem_err(e3)
`ifdef PV32_CONSOLE_EN
    , .console_valid(cv3), .console_data(cd3)
`endif
  );

`ifndef PV32_CONSOLE_EN
  assign cv0 = 1'b0;
  assign cd0 = 8'd0;
  assign cv3 = 1'b0;
  assign cd3 = 8'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input string tag, output logic [31:0] rdo);
    int lat;
    int exp_lat;
    exp_lat = sel ? 4 : 1;
    @(negedge clk);
    addr  = a;
    wdata = wd;
    wstrb = ws;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if ((sel ? r3 : r0) === 1'b1) begin
        lat = n;
        break;
      end
    end
    rdo        = sel ? rd3 : rd0;
    last_cv_at = sel ? cv3 : cv0;
    last_cd_at = sel ? cd3 : cd0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    chk({tag, "_onecycle"}, {31'd0, (sel ? r3 : r0)}, 32'd0);
    last_cv_after = sel ? cv3 : cv0;
    v0 = 1'b0;
    v3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    v0 = 1'b0; v3 = 1'b0; instr = 1'b0;
    addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    last_cv_at = 1'b0; last_cv_after = 1'b0; last_cd_at = 8'd0;
    #22;
    chk("rst_ready0", {31'd0, r0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err0",   {31'd0, e0}, 32'd0);
    chk("rst_ready3", {31'd0, r3}, 32'd0);
    chk("rst_rdata3", rd3, 32'd0);
    chk("rst_err3",   {31'd0, e3}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Zero wait states: full write, read back, then single-byte merge.
    do_req(0, 32'h0, 32'hDEAD_BEEF, 4'hF, "ws0_w0", rd);
    do_req(0, 32'h0, 32'h0, 4'h0, "ws0_r0", rd);
    chk("ws0_r0_data", rd, 32'hDEAD_BEEF);
    do_req(0, 32'h4, 32'hFFFF_FFFF, 4'hF, "ws0_w4", rd);
    do_req(0, 32'h4, 32'h0000_5A00, 4'b0010, "ws0_w4b1", rd);
    do_req(0, 32'h4, 32'h0, 4'h0, "ws0_r4", rd);
    chk("ws0_r4_data", rd, 32'hFFFF_5AFF);

    // Three wait states: preset, strobed write, read-after-write.
    do_req(1, 32'h10, 32'hAAAA_AAAA, 4'hF, "ws3_pre", rd);
    do_req(1, 32'h10, 32'h1122_3344, 4'b0101, "ws3_wstrb", rd);
    do_req(1, 32'h10, 32'h0, 4'h0, "ws3_r10", rd);
    chk("ws3_r10_data", rd, 32'hAA22_AA44);
    do_req(1, 32'h14, 32'h0, 4'hF, "ws3_w14", rd);
    chk("ws3_rdata_hold", rd3, 32'hAA22_AA44);

    // Out-of-range read, dropped out-of-range write aliasing word 1, in-range write after.
    do_req(0, 32'h400, 32'h0, 4'h0, "oor_r", rd);
    chk("oor_r_data", rd, 32'h0);
    chk("oor_err_set", {31'd0, e0}, 32'd1);
    do_req(0, 32'h404, 32'h0, 4'hF, "oor_w", rd);
    do_req(0, 32'h4, 32'h0, 4'h0, "oor_w_dropped", rd);
    chk("oor_w_dropped_data", rd, 32'hFFFF_5AFF);
    do_req(0, 32'h8, 32'hCAFE_F00D, 4'hF, "after_oor_w", rd);
    do_req(0, 32'h8, 32'h0, 4'h0, "after_oor_r", rd);
    chk("after_oor_data", rd, 32'hCAFE_F00D);
    chk("oor_err_sticky", {31'd0, e0}, 32'd1);

`ifdef PV32_CONSOLE_EN
    do_req(1, 32'h100, 32'h0000_0048, 4'hF, "con_w", rd);
    chk("con_valid_pulse", {31'd0, last_cv_at}, 32'd1);
    chk("con_data", {24'd0, last_cd_at}, 32'h48);
    chk("con_valid_end", {31'd0, last_cv_after}, 32'd0);
    chk("con_err", {31'd0, e3}, 32'd0);
    do_req(1, 32'h100, 32'h0, 4'h0, "con_r", rd);
    chk("con_r_data", rd, 32'h0);
`else
    do_req(1, 32'h100, 32'h0000_0048, 4'hF, "w100", rd);
    do_req(1, 32'h100, 32'h0, 4'h0, "r100", rd);
    chk("r100_data", rd, 32'h0000_0048);
    chk("w100_err", {31'd0, e3}, 32'd0);
`endif

    // Reset asserted while a write sits in WAIT: write must be lost.
    do_req(1, 32'h20, 32'h0101_0101, 4'hF, "mid_pre", rd);
    @(negedge clk);
    addr = 32'h20; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; v3 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, r3}, 32'd0);
    chk("mid_rst_rdata", rd3, 32'd0);
    chk("mid_rst_err0",  {31'd0, e0}, 32'd0);
    chk("mid_rst_con",   {31'd0, cv3}, 32'd0);
    v3 = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (r3 !== 1'b0) seen = 1'b1;
    end
    chk("mid_rst_noready", {31'd0, seen}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_req(1, 32'h20, 32'h0, 4'h0, "mid_rst_r", rd);
    chk("mid_rst_word", rd, 32'h0101_0101);

    // Valid dropped during WAIT: abort with no write and no ready.
    @(negedge clk);
    addr = 32'h20; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (r3 !== 1'b0) seen = 1'b1;
    end
    chk("abort_noready", {31'd0, seen}, 32'd0);
    do_req(1, 32'h20, 32'h0, 4'h0, "abort_r", rd);
    chk("abort_word", rd, 32'h0101_0101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
